// File: rtl/sonar_ranger.sv
// sonar_ranger: ultrasonic trigger/echo timer with done/busy handshake
// and a free-running microsecond counter.
module sonar_ranger #(
  parameter int CLKS_PER_US = 50,
  parameter int TRIG_US     = 10,
  parameter int TIMEOUT_US  = 30000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        echo,
  output logic        trig,
  output logic        busy,
  output logic        done,
  output logic        timed_out,
  output logic [31:0] echo_us,
  output logic [31:0] us_clock
);

  localparam logic [31:0] US_LAST   = 32'(CLKS_PER_US - 1);
  localparam logic [31:0] TRIG_LAST = 32'(TRIG_US * CLKS_PER_US - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_US * CLKS_PER_US - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [31:0] pre;
  logic [31:0] cyc, cyc_n;
  logic [31:0] sub, sub_n;
  logic [31:0] width, width_n;
  logic [31:0] width_inc;
  logic        echo_s1, echo_s2, echo_d;
  logic        rise, fall;
  logic        ld_meas, ld_tmo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre      <= '0;
      us_clock <= '0;
    end else if (pre == US_LAST) begin
      pre      <= '0;
      us_clock <= us_clock + 32'd1;
    end else begin
      pre <= pre + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_d  <= 1'b0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_d  <= echo_s2;
    end
  end

  assign rise = echo_s2 & ~echo_d;
  assign fall = ~echo_s2 & echo_d;

  always_comb begin
    width_inc = width;
    if (sub == US_LAST && width != 32'hFFFF_FFFF)
      width_inc = width + 32'd1;
  end

  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    sub_n   = sub;
    width_n = width;
    ld_meas = 1'b0;
    ld_tmo  = 1'b0;
    unique case (state)
      IDLE: begin
        cyc_n = '0;
        if (start)
          state_n = TRIG;
      end
      TRIG: begin
        if (cyc == TRIG_LAST) begin
          state_n = WAIT_RISE;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc + 32'd1;
        end
      end
      WAIT_RISE: begin
        // timeout checked first so a late rise cannot escape the limit
        if (cyc == TMO_LAST) begin
          state_n = DONE;
          ld_tmo  = 1'b1;
        end else begin
          cyc_n = cyc + 32'd1;
          if (rise) begin
            state_n = MEASURE;
            sub_n   = '0;
            width_n = '0;
          end
        end
      end
      MEASURE: begin
        sub_n   = (sub == US_LAST) ? '0 : sub + 32'd1;
        width_n = width_inc;
        if (fall) begin
          state_n = DONE;
          ld_meas = 1'b1;
        end else if (cyc == TMO_LAST) begin
          state_n = DONE;
          ld_tmo  = 1'b1;
        end else begin
          cyc_n = cyc + 32'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cyc   <= '0;
      sub   <= '0;
      width <= '0;
    end else begin
      state <= state_n;
      cyc   <= cyc_n;
      sub   <= sub_n;
      width <= width_n;
    end
  end

  // outputs decoded from the next state so they are clean flop outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trig <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      trig <= (state_n == TRIG);
      busy <= (state_n == TRIG) ||
              (state_n == WAIT_RISE) ||
              (state_n == MEASURE);
      done <= (state_n == DONE);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_us   <= '0;
      timed_out <= 1'b0;
    end else if (ld_meas) begin
      echo_us   <= width_n;
      timed_out <= 1'b0;
    end else if (ld_tmo) begin
      echo_us   <= '0;
      timed_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sonar_ranger.sv
// tb_sonar_ranger: randomized self-checking bench for sonar_ranger
// against a cycle-count arithmetic reference model.
module tb_sonar_ranger;

  localparam int C   = 4;
  localparam int TU  = 10;
  localparam int TO  = 100;
  localparam int LIM = TO * C;
  localparam int TRC = TU * C;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        echo  = 1'b0;
  logic        trig, busy, done, timed_out;
  logic [31:0] echo_us, us_clock;

  int checks   = 0;
  int failures = 0;

  sonar_ranger #(
    .CLKS_PER_US(C),
    .TRIG_US(TU),
    .TIMEOUT_US(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .echo(echo),
    .trig(trig),
    .busy(busy),
    .done(done),
    .timed_out(timed_out),
    .echo_us(echo_us),
    .us_clock(us_clock)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Expected result, in cycles counted from the edge where trig drops.
  // Echo high from cycle d for w sampled edges; done lands 3 edges after
  // the first low sample, unless the limit is reached first.
  function automatic void model(input int d, input int w, input bit pre,
                                output int k, output logic [31:0] us,
                                output logic to);
    if (pre || w == 0 || d + w + 3 > LIM) begin
      k  = LIM;
      us = 32'd0;
      to = 1'b1;
    end else begin
      k  = d + w + 3;
      us = 32'(w / C);
      to = 1'b0;
    end
  endfunction

  task automatic do_meas(input int d, input int w, input bit pre,
                         input int start_at, input bit start_in_done,
                         output int trig_len, output logic busy0,
                         output int done_k, output logic busy_dn,
                         output logic [31:0] us_o, output logic to_o,
                         output int extra_done, output int extra_trig);
    int k;
    start = 1'b1;
    tick();
    busy0 = busy;
    start = 1'b0;
    trig_len = 0;
    while (trig && trig_len < 100) begin
      if (pre && trig_len == 20) echo = 1'b1;
      tick();
      trig_len++;
    end
    done_k = -1;
    k = 0;
    while (k < 600) begin
      echo  = pre ? 1'b1 : (k >= d && k < d + w);
      start = (k == start_at);
      tick();
      k++;
      if (done) begin
        done_k = k;
        break;
      end
    end
    start   = 1'b0;
    busy_dn = busy;
    us_o    = echo_us;
    to_o    = timed_out;
    echo    = 1'b0;
    if (start_in_done) start = 1'b1;
    extra_done = 0;
    extra_trig = 0;
    repeat (60) begin
      tick();
      start = 1'b0;
      if (done) extra_done++;
      if (trig) extra_trig++;
    end
  endtask

  task automatic test_reset;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    checks++;
    if ({trig, busy, done, timed_out} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000",
               {trig, busy, done, timed_out});
    end
    checks++;
    if (echo_us !== 32'd0) begin
      failures++;
      $display("FAIL reset_echo_us: got %0d expected 0", echo_us);
    end
    checks++;
    if (us_clock !== 32'd0) begin
      failures++;
      $display("FAIL reset_us_clock: got %0d expected 0", us_clock);
    end
    repeat (40) tick();
    checks++;
    if (us_clock !== 32'd10) begin
      failures++;
      $display("FAIL us_clock_40: got %0d expected 10", us_clock);
    end
  endtask

  task automatic test_echo_width;
    int tl, dk, ed, et, ek;
    logic b0, bd, to, eto;
    logic [31:0] us, eus;
    do_meas(0, 200, 1'b0, -1, 1'b0, tl, b0, dk, bd, us, to, ed, et);
    model(0, 200, 1'b0, ek, eus, eto);
    checks++;
    if (tl !== TRC) begin
      failures++;
      $display("FAIL trig_len: got %0d expected %0d", tl, TRC);
    end
    checks++;
    if (b0 !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_start: got %b expected 1", b0);
    end
    checks++;
    if (dk !== ek) begin
      failures++;
      $display("FAIL width_done_cycle: got %0d expected %0d", dk, ek);
    end
    checks++;
    if (us !== eus || to !== eto) begin
      failures++;
      $display("FAIL width_result: got us=%0d to=%b expected us=%0d to=%b",
               us, to, eus, eto);
    end
    checks++;
    if (bd !== 1'b0 || ed !== 0) begin
      failures++;
      $display("FAIL width_done_pulse: got busy=%b extra=%0d expected 0 0",
               bd, ed);
    end
  endtask

  task automatic test_timeout;
    int tl, dk, ed, et, ek;
    logic b0, bd, to, eto;
    logic [31:0] us, eus;
    do_meas(0, 0, 1'b0, -1, 1'b0, tl, b0, dk, bd, us, to, ed, et);
    model(0, 0, 1'b0, ek, eus, eto);
    checks++;
    if (dk !== ek || us !== eus || to !== eto) begin
      failures++;
      $display("FAIL no_echo_tmo: got k=%0d us=%0d to=%b expected k=%0d us=%0d to=%b",
               dk, us, to, ek, eus, eto);
    end
    do_meas(7, 202, 1'b0, -1, 1'b0, tl, b0, dk, bd, us, to, ed, et);
    model(7, 202, 1'b0, ek, eus, eto);
    checks++;
    if (dk !== ek || us !== eus || to !== eto) begin
      failures++;
      $display("FAIL after_tmo: got k=%0d us=%0d to=%b expected k=%0d us=%0d to=%b",
               dk, us, to, ek, eus, eto);
    end
  endtask

  task automatic test_fall_vs_timeout;
    int tl, dk, ed, et, ek;
    logic b0, bd, to, eto;
    logic [31:0] us, eus;
    for (int w = LIM - 3; w <= LIM - 2; w++) begin
      do_meas(0, w, 1'b0, -1, 1'b0, tl, b0, dk, bd, us, to, ed, et);
      model(0, w, 1'b0, ek, eus, eto);
      checks++;
      if (dk !== ek || us !== eus || to !== eto) begin
        failures++;
        $display("FAIL edge_w%0d: got k=%0d us=%0d to=%b expected k=%0d us=%0d to=%b",
                 w, dk, us, to, ek, eus, eto);
      end
    end
  endtask

  task automatic test_ignored_start;
    int tl, dk, ed, et, ek;
    logic b0, bd, to, eto;
    logic [31:0] us, eus;
    do_meas(0, 100, 1'b0, 50, 1'b1, tl, b0, dk, bd, us, to, ed, et);
    model(0, 100, 1'b0, ek, eus, eto);
    checks++;
    if (dk !== ek || us !== eus || to !== eto) begin
      failures++;
      $display("FAIL start_ign_res: got k=%0d us=%0d to=%b expected k=%0d us=%0d to=%b",
               dk, us, to, ek, eus, eto);
    end
    checks++;
    if (ed !== 0 || et !== 0) begin
      failures++;
      $display("FAIL start_ign_extra: got dones=%0d trigs=%0d expected 0 0",
               ed, et);
    end
    do_meas(0, 0, 1'b1, -1, 1'b0, tl, b0, dk, bd, us, to, ed, et);
    model(0, 0, 1'b1, ek, eus, eto);
    checks++;
    if (dk !== ek || us !== eus || to !== eto) begin
      failures++;
      $display("FAIL pre_high: got k=%0d us=%0d to=%b expected k=%0d us=%0d to=%b",
               dk, us, to, ek, eus, eto);
    end
  endtask

  task automatic test_reset_mid_measure;
    int tl, dk, ed, et, ek, nd;
    logic b0, bd, to, eto;
    logic [31:0] us, eus;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (45) tick();
    echo = 1'b1;
    repeat (30) tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_busy: got %b expected 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({trig, busy, done} !== 3'b0 || us_clock !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset: got tbd=%b us_clock=%0d expected 000 0",
               {trig, busy, done}, us_clock);
    end
    tick();
    reset = 1'b0;
    echo  = 1'b0;
    nd = 0;
    repeat (500) begin
      tick();
      if (done) nd++;
    end
    checks++;
    if (nd !== 0) begin
      failures++;
      $display("FAIL post_reset_done: got %0d expected 0", nd);
    end
    do_meas(5, 100, 1'b0, -1, 1'b0, tl, b0, dk, bd, us, to, ed, et);
    model(5, 100, 1'b0, ek, eus, eto);
    checks++;
    if (tl !== TRC || dk !== ek || us !== eus || to !== eto) begin
      failures++;
      $display("FAIL post_reset_meas: got t=%0d k=%0d us=%0d to=%b expected t=%0d k=%0d us=%0d to=%b",
               tl, dk, us, to, TRC, ek, eus, eto);
    end
  endtask

  task automatic test_random;
    int tl, dk, ed, et, ek, d, w;
    logic b0, bd, to, eto;
    logic [31:0] us, eus;
    for (int i = 0; i < 8; i++) begin
      d = int'($urandom_range(0, 40));
      w = int'($urandom_range(1, 420));
      do_meas(d, w, 1'b0, -1, 1'b0, tl, b0, dk, bd, us, to, ed, et);
      model(d, w, 1'b0, ek, eus, eto);
      checks++;
      if (dk !== ek || us !== eus || to !== eto || ed !== 0) begin
        failures++;
        $display("FAIL rand d=%0d w=%0d: got k=%0d us=%0d to=%b x=%0d expected k=%0d us=%0d to=%b x=0",
                 d, w, dk, us, to, ed, ek, eus, eto);
      end
    end
  endtask

  initial begin
    test_reset();
    test_echo_width();
    test_timeout();
    test_fall_vs_timeout();
    test_ignored_start();
    test_reset_mid_measure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sonar_ranger.md
Name: sonar_ranger

Overview:
Ultrasonic ranging front end that sits between the sonar I/O pins and the processor/regfile.
- Generates the trigger pulse and times the echo pulse width in microseconds.
- Hands the result to the processor with a done/busy handshake.
- Produces the free-running microsecond counter that the regfile exposes as reg3 (us_clock).

Parameters:
CLKS_PER_US, 50, clock cycles per microsecond (>=2)
TRIG_US, 10, trigger pulse length in microseconds
TIMEOUT_US, 30000, max microseconds from trigger end to echo fall before abort

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a measurement; sampled only in IDLE
echo  input  1  raw echo pin, asynchronous to clock
trig  output  1  trigger pin drive
busy  output  1  measurement in progress
done  output  1  one-cycle pulse: result valid
timed_out  output  1  last measurement aborted by timeout
echo_us  output  32  last echo width in microseconds
us_clock  output  32  free-running microsecond counter

Behaviour:
- Clock and reset: one clock (clock). Reset is asynchronous and active-high (reset).
- Reset values: all outputs 0. State is IDLE. Prescalers, counters and sync flops are cleared. Reset mid-operation aborts immediately: trig drops asynchronously and no done is issued.
- us_clock:
  - Prescaler counts 0..CLKS_PER_US-1. us_clock increments on the cycle the prescaler wraps.
  - Wraps 0xFFFFFFFF -> 0.
  - Independent of the FSM; never stalls.
- echo sync:
  - Two flops: echo_s1, echo_s2. Delay flop echo_d follows echo_s2.
  - rise = echo_s2 & ~echo_d; fall = ~echo_s2 & echo_d.
  - FSM uses only rise/fall.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, DONE.
  - IDLE: start=1 -> TRIG. Cycle counter cleared.
  - TRIG:
    - trig=1 for exactly TRIG_US*CLKS_PER_US cycles, counted in cycles rather than us ticks.
    - Then -> WAIT_RISE. Timeout cycle counter cleared.
  - WAIT_RISE:
    - rise -> MEASURE. Width counter and sub-us counter cleared.
    - If echo is already high on entry, the block waits for a fresh rising edge.
  - MEASURE:
    - Sub-counter increments each cycle. On wrap at CLKS_PER_US-1, width increments (saturating at 0xFFFFFFFF).
    - fall -> DONE with echo_us <= width, i.e. floor(high cycles / CLKS_PER_US), and timed_out <= 0.
  - Timeout (WAIT_RISE and MEASURE):
    - The cycle counter runs from WAIT_RISE entry.
    - When it reaches TIMEOUT_US*CLKS_PER_US -> DONE with echo_us <= 0 and timed_out <= 1.
    - If fall and timeout occur in the same cycle, fall wins.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- busy = state in {TRIG, WAIT_RISE, MEASURE}. busy is low in the DONE cycle.
- Start handling: start while not in IDLE, including the DONE cycle, is ignored and not queued.
- echo_us and timed_out are registered. They are updated only on entry to DONE and hold until the next DONE.
- Latency: take the first rising edge at which the echo pin is sampled low as edge 1. done is high after edge 3 (two sync edges plus the edge-detect/state edge).
- trig is registered, high exactly while in TRIG, and glitch-free.

Test Plan:
(Parameters CLKS_PER_US=4, TRIG_US=10, TIMEOUT_US=100.)
1. Reset asserted mid-cycle, then released -> trig, busy, done, timed_out = 0; echo_us=0; us_clock=0. After 40 clocks, us_clock=10.
2. One-cycle start pulse in IDLE -> trig high for exactly 40 cycles, then low; busy high from the cycle after start.
3. After trig ends, echo held high for 200 cycles, then low -> done pulses once, 3 edges after echo low. echo_us=50, timed_out=0, busy=0 in the done cycle.
4. start, echo never rises -> exactly 400 cycles after WAIT_RISE entry, done pulses with timed_out=1 and echo_us=0. A following good measurement with 202 high cycles gives echo_us=50 and timed_out=0.
5. start pulsed during MEASURE and during DONE -> ignored: one done only, no second trig. Then drive echo high before trig ends and hold it -> no rise seen, so the measurement times out.
6. Reset asserted during MEASURE -> trig and busy are 0 immediately, no done, us_clock=0. A fresh start afterwards completes normally.
